// File: rtl/mips_enc_pkg.sv
// Shared encodings for the MIPS program builder: request kinds, primary opcodes
// and the builder FSM states.
package mips_enc_pkg;

  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_BEQ   = 3'd3,
    K_ADDI  = 3'd4,
    K_J     = 3'd5
  } kind_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HALT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: request kind plus register/immediate fields -> 32-bit
// MIPS word. Kinds 6/7 yield a zero word and raise illegal.
module instr_pack
  import mips_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind_t'(kind))
      K_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
      K_LW:    word = {OP_LW, rs, rt, imm};
      K_SW:    word = {OP_SW, rs, rt, imm};
      K_BEQ:   word = {OP_BEQ, rs, rt, imm};
      K_ADDI:  word = {OP_ADDI, rs, rt, imm};
      K_J:     word = {OP_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential program builder writing packed MIPS words into imem, with a
// jump-to-self terminator on finish. ENCODER_ERRCHK_EN adds the sticky err port.
module instr_encoder
  import mips_enc_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          finish,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
`ifdef ENCODER_ERRCHK_EN
  output logic          err,
`endif
  output state_t        dbg_state
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] ptr;
  logic [31:0]   pk_word;
  logic          pk_illegal;
  logic          accept;
  logic          drop;

  instr_pack u_pack (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  // Handshake: a beat transfers when in_valid && in_ready at clk rise; in_ready
  // never depends on in_valid, and the last slot is reserved for the halt word.
  assign in_ready  = (state == LOAD) && (ptr < LAST) && !finish && !start;
  assign accept    = in_valid && in_ready;
  assign full      = (state == LOAD) && (ptr == LAST);
  assign dbg_state = state;

`ifdef ENCODER_ERRCHK_EN
  assign drop = pk_illegal || ((in_kind == K_RTYPE) && (in_rd == 5'd0));
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      ptr       <= '0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= '0;
      count     <= '0;
      done      <= 1'b0;
`ifdef ENCODER_ERRCHK_EN
      err       <= 1'b0;
`endif
    end else if (start) begin
      state   <= LOAD;
      ptr     <= '0;
      imem_we <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
`ifdef ENCODER_ERRCHK_EN
      err     <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        LOAD: begin
          if (finish) begin
            // Terminator is a jump to its own word address.
            imem_we   <= 1'b1;
            imem_addr <= ptr;
            imem_wd   <= {OP_J, 26'(ptr)};
            count     <= (AW+1)'(ptr) + (AW+1)'(1);
            done      <= 1'b1;
            state     <= HALT;
          end else if (accept) begin
            if (drop) begin
`ifdef ENCODER_ERRCHK_EN
              err <= 1'b1;
`endif
            end else begin
              imem_we   <= 1'b1;
              imem_addr <= ptr;
              imem_wd   <= pk_illegal ? 32'h0000_0000 : pk_word;
              ptr       <= ptr + AW'(1);
              count     <= count + (AW+1)'(1);
            end
          end
        end
        HALT:    state <= DONE;
        DONE:    state <= DONE;
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of packed-word vectors plus hand
// sequences for finish, full, start/reset priority and illegal kinds.
module tb_instr_encoder;
  import mips_enc_pkg::*;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_wd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        finish;

  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wd;
  logic [6:0]  count;
  logic        full;
  logic        done;
  state_t      dbg_state;

  logic        s_in_ready;
  logic        s_imem_we;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wd;
  logic [2:0]  s_count;
  logic        s_full;
  logic        s_done;
  state_t      s_dbg_state;
`ifdef ENCODER_ERRCHK_EN
  logic        err;
  logic        s_err;
`endif

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];
  vec_t tbl[6];
  vec_t ill;

  instr_encoder #(.DEPTH(64)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .finish(finish), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .count(count), .full(full), .done(done),
`ifdef ENCODER_ERRCHK_EN
    .err(err),
`endif
    .dbg_state(dbg_state)
  );

  instr_encoder #(.DEPTH(4)) u_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .finish(finish), .imem_we(s_imem_we),
    .imem_addr(s_imem_addr), .imem_wd(s_imem_wd), .count(s_count), .full(s_full),
    .done(s_done),
`ifdef ENCODER_ERRCHK_EN
    .err(s_err),
`endif
    .dbg_state(s_dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid  = 1'b1;
    in_kind   = v.kind;
    in_rs     = v.rs;
    in_rt     = v.rt;
    in_rd     = v.rd;
    in_funct  = v.funct;
    in_imm    = v.imm;
    in_target = v.target;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_kind   = 3'd0;
    in_rs     = '0;
    in_rt     = '0;
    in_rd     = '0;
    in_funct  = '0;
    in_imm    = '0;
    in_target = '0;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    // Unused fields carry junk to show they are ignored.
    tbl[0] = '{3'd0, 5'd1, 5'd2, 5'd3,  6'h20, 16'hBEEF, 26'h3FFFFFF, 32'h00221820};
    tbl[1] = '{3'd1, 5'd0, 5'd2, 5'd31, 6'h3F, 16'h0004, 26'h1234567, 32'h8C020004};
    tbl[2] = '{3'd2, 5'd0, 5'd2, 5'd7,  6'h11, 16'h0008, 26'h0ABCDEF, 32'hAC020008};
    tbl[3] = '{3'd3, 5'd1, 5'd2, 5'd9,  6'h01, 16'hFFFF, 26'h2222222, 32'h1022FFFF};
    tbl[4] = '{3'd4, 5'd0, 5'd1, 5'd4,  6'h2A, 16'h0005, 26'h1111111, 32'h20010005};
    tbl[5] = '{3'd5, 5'd31, 5'd30, 5'd29, 6'h3F, 16'hFFFF, 26'h0000010, 32'h08000010};
    ill    = '{3'd7, 5'd5, 5'd6, 5'd7,  6'h20, 16'h1234, 26'h0000055, 32'h00000000};

    reset  = 1'b1;
    start  = 1'b0;
    finish = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wd", imem_wd, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(LOAD));
    chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef ENCODER_ERRCHK_EN
    chk("rst_err", 32'(err), 32'd0);
`endif

    // Back-to-back packing, one write per cycle
    for (int i = 0; i < 6; i++) begin
      drive_vec(tbl[i]);
      exp_q.push_back(tbl[i].exp_wd);
      #1;
      chk("b2b_ready", 32'(in_ready), 32'd1);
      tick();
      chk("b2b_we", 32'(imem_we), 32'd1);
      chk("b2b_addr", 32'(imem_addr), 32'(i));
      chk("b2b_wd", imem_wd, exp_q.pop_front());
      chk("b2b_count", 32'(count), 32'(i + 1));
    end
    idle();
    tick();
    chk("idle_we", 32'(imem_we), 32'd0);
    chk("hold_addr", 32'(imem_addr), 32'd5);
    chk("hold_wd", imem_wd, 32'h08000010);

    // Three accepts then finish
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_count", 32'(count), 32'd0);
    chk("start_state", 32'(dbg_state), 32'(LOAD));
    for (int i = 0; i < 3; i++) begin
      drive_vec(tbl[i]);
      tick();
      chk("fin_acc_addr", 32'(imem_addr), 32'(i));
    end
    idle();
    finish = 1'b1;
    #1;
    chk("fin_blocks_ready", 32'(in_ready), 32'd0);
    tick();
    finish = 1'b0;
    chk("halt_we", 32'(imem_we), 32'd1);
    chk("halt_addr", 32'(imem_addr), 32'd3);
    chk("halt_wd", imem_wd, 32'h08000003);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_count", 32'(count), 32'd4);
    #1;
    chk("halt_ready", 32'(in_ready), 32'd0);
    tick();
    chk("done_we", 32'(imem_we), 32'd0);
    chk("done_state", 32'(dbg_state), 32'(DONE));
    drive_vec(tbl[0]);
    finish = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_ignore_we", 32'(imem_we), 32'd0);
      chk("done_ignore_count", 32'(count), 32'd4);
    end
    idle();
    finish = 1'b0;
    chk("done_level", 32'(done), 32'd1);

    // DEPTH=4: full blocks further beats, halt still lands in the last slot
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_vec(tbl[i]);
      tick();
      chk("s_acc_we", 32'(s_imem_we), 32'd1);
      chk("s_acc_addr", 32'(s_imem_addr), 32'(i));
    end
    drive_vec(tbl[3]);
    #1;
    chk("s_full", 32'(s_full), 32'd1);
    chk("s_ready", 32'(s_in_ready), 32'd0);
    tick();
    tick();
    chk("s_held_we", 32'(s_imem_we), 32'd0);
    chk("s_held_count", 32'(s_count), 32'd3);
    idle();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("s_halt_we", 32'(s_imem_we), 32'd1);
    chk("s_halt_addr", 32'(s_imem_addr), 32'd3);
    chk("s_halt_wd", s_imem_wd, 32'h08000003);
    chk("s_halt_count", 32'(s_count), 32'd4);
    chk("s_halt_done", 32'(s_done), 32'd1);

    // start wins over in_valid in the same cycle
    drive_vec(tbl[0]);
    start = 1'b1;
    #1;
    chk("start_ready", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
    chk("start_v_count", 32'(count), 32'd0);
    chk("start_v_we", 32'(imem_we), 32'd0);
    tick();
    chk("post_start_we", 32'(imem_we), 32'd1);
    chk("post_start_addr", 32'(imem_addr), 32'd0);
    chk("post_start_wd", imem_wd, tbl[0].exp_wd);
    chk("post_start_count", 32'(count), 32'd1);

    // Reset cancels a write accepted on the same edge
    drive_vec(tbl[1]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("rst_cancel_we", 32'(imem_we), 32'd0);
    chk("rst_cancel_wd", imem_wd, 32'd0);
    chk("rst_cancel_count", 32'(count), 32'd0);

    // Illegal kind
    drive_vec(ill);
    tick();
    idle();
`ifdef ENCODER_ERRCHK_EN
    chk("ill_we", 32'(imem_we), 32'd0);
    chk("ill_count", 32'(count), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
`else
    chk("ill_we", 32'(imem_we), 32'd1);
    chk("ill_addr", 32'(imem_addr), 32'd0);
    chk("ill_wd", imem_wd, 32'h00000000);
    chk("ill_count", 32'(count), 32'd1);
`endif
    drive_vec(tbl[0]);
    tick();
    idle();
    chk("after_ill_we", 32'(imem_we), 32'd1);
    chk("after_ill_wd", imem_wd, tbl[0].exp_wd);
`ifdef ENCODER_ERRCHK_EN
    chk("after_ill_addr", 32'(imem_addr), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    ill.kind = 3'd0;
    ill.rd   = 5'd0;
    drive_vec(ill);
    tick();
    idle();
    chk("rd0_we", 32'(imem_we), 32'd0);
    chk("rd0_count", 32'(count), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clear", 32'(err), 32'd0);
`else
    chk("after_ill_addr", 32'(imem_addr), 32'd1);
    ill.kind = 3'd6;
    drive_vec(ill);
    tick();
    idle();
    chk("ill6_wd", imem_wd, 32'h00000000);
    chk("ill6_addr", 32'(imem_addr), 32'd2);
    chk("ill6_count", 32'(count), 32'd3);
`endif

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
